// File: rtl/carry_select_adder_pkg.sv
// Shared helpers for the carry-select adder: full-adder equations and
// block-count arithmetic used by the top level and its ripple sub-blocks.
package carry_select_adder_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_BLOCK_W = 2;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (c & (x ^ y));
    endfunction

    function automatic int num_blocks(input int width, input int block_w);
        return width / block_w;
    endfunction

endpackage

// File: rtl/carry_select_adder_ripple_block.sv
// W-bit ripple-carry adder built from full-adder equations; the building
// block for both the block-0 chain and the speculative upper-block pairs.
module ripple_block
    import carry_select_adder_pkg::*;
#(
    parameter int W = DEF_BLOCK_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = fa_sum(a[i], b[i], c[i]);
        assign c[i+1] = fa_carry(a[i], b[i], c[i]);
    end

    assign co = c[W];

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: block 0 ripples from cin, each higher block
// precomputes both carry-in cases and a mux chain picks the real one.
module carry_select_adder
    import carry_select_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    localparam int NB = num_blocks(WIDTH, BLOCK_W);

    if (WIDTH < 2 || BLOCK_W < 1 || (WIDTH % BLOCK_W) != 0) begin : g_bad_cfg
        $error("carry_select_adder: WIDTH must be >= 2 and a multiple of BLOCK_W");
    end

    // blk_c[k] is the resolved carry into block k; blk_c[NB] is the carry-out.
    logic [NB:0]        blk_c;
    logic [WIDTH-1:0]   s_sel;
    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     sum_q;

    assign blk_c[0] = cin;

    ripple_block #(.W(BLOCK_W)) u_blk0 (
        .a  (a[BLOCK_W-1:0]),
        .b  (b[BLOCK_W-1:0]),
        .ci (blk_c[0]),
        .s  (s_sel[BLOCK_W-1:0]),
        .co (blk_c[1])
    );

    for (genvar k = 1; k < NB; k++) begin : g_sel
        logic [BLOCK_W-1:0] s0;
        logic [BLOCK_W-1:0] s1;
        logic               c0;
        logic               c1;

        ripple_block #(.W(BLOCK_W)) u_rb0 (
            .a  (a[k*BLOCK_W +: BLOCK_W]),
            .b  (b[k*BLOCK_W +: BLOCK_W]),
            .ci (1'b0),
            .s  (s0),
            .co (c0)
        );

        ripple_block #(.W(BLOCK_W)) u_rb1 (
            .a  (a[k*BLOCK_W +: BLOCK_W]),
            .b  (b[k*BLOCK_W +: BLOCK_W]),
            .ci (1'b1),
            .s  (s1),
            .co (c1)
        );

        // Only these muxes sit on the carry path above block 0.
        assign s_sel[k*BLOCK_W +: BLOCK_W] = blk_c[k] ? s1 : s0;
        assign blk_c[k+1]                  = blk_c[k] ? c1 : c0;
    end

    assign sum_d = {blk_c[NB], s_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench for carry_select_adder: directed cases, reset behaviour,
// exhaustive 4-bit sweep and random 8-bit vectors against an arithmetic model.
module tb_carry_select_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a4, b4;
    logic       cin4;
    logic [4:0] sum4;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [8:0] sum8;

    int n_cmp;
    int n_err;

    carry_select_adder #(.WIDTH(4), .BLOCK_W(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .sum   (sum4)
    );

    carry_select_adder #(.WIDTH(8), .BLOCK_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return 5'(r);
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return 9'(r);
    endfunction

    task automatic drive4(input logic [3:0] x, input logic [3:0] y, input logic c);
        @(negedge clk);
        a4 = x; b4 = y; cin4 = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
        a8 = 8'hFF;   b8 = 8'hFF;   cin8 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sum4 !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_async4 got=%b want=%b", sum4, 5'b00000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (sum4 !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_hold4[%0d] got=%b want=%b", i, sum4, 5'b00000);
            end
            n_cmp++;
            if (sum8 !== 9'd0) begin
                n_err++;
                $display("FAIL reset_hold8[%0d] got=%b want=%b", i, sum8, 9'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (sum4 !== 5'd31) begin
            n_err++;
            $display("FAIL reset_release4 got=%b want=%b", sum4, 5'd31);
        end
        n_cmp++;
        if (sum8 !== 9'd511) begin
            n_err++;
            $display("FAIL reset_release8 got=%b want=%b", sum8, 9'd511);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ta [6];
        logic [3:0] tb [6];
        logic       tc [6];
        logic [4:0] te [6];
        ta = '{4'b0101, 4'b0000, 4'b1111, 4'b1010, 4'b1010, 4'b1100};
        tb = '{4'b0011, 4'b0000, 4'b0001, 4'b0110, 4'b1010, 4'b0011};
        tc = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
        te = '{5'b01000, 5'b00001, 5'b10001, 5'b10000, 5'b10100, 5'b10000};
        for (int i = 0; i < 6; i++) begin
            drive4(ta[i], tb[i], tc[i]);
            @(posedge clk); #1;
            n_cmp++;
            if (sum4 !== te[i]) begin
                n_err++;
                $display("FAIL directed[%0d] a=%b b=%b cin=%b got=%b want=%b",
                         i, ta[i], tb[i], tc[i], sum4, te[i]);
            end
        end
    endtask

    task automatic test_single_change();
        logic [4:0] prev;
        drive4(4'd3, 4'd5, 1'b0);
        @(posedge clk); #1;
        prev = ref4(a4, b4, cin4);
        for (int step = 0; step < 3; step++) begin
            @(negedge clk);
            case (step)
                0:       a4   = 4'd12;
                1:       b4   = 4'd6;
                default: cin4 = 1'b1;
            endcase
            #1;
            n_cmp++;
            if (sum4 !== prev) begin
                n_err++;
                $display("FAIL single_hold[%0d] got=%b want=%b", step, sum4, prev);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (sum4 !== ref4(a4, b4, cin4)) begin
                n_err++;
                $display("FAIL single_change[%0d] got=%b want=%b", step, sum4, ref4(a4, b4, cin4));
            end
            prev = ref4(a4, b4, cin4);
        end
    endtask

    task automatic test_midrun_reset();
        drive4(4'd9, 4'd9, 1'b1);
        a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sum4 !== 5'd0) begin
            n_err++;
            $display("FAIL midrun_clear4 got=%b want=%b", sum4, 5'd0);
        end
        n_cmp++;
        if (sum8 !== 9'd0) begin
            n_err++;
            $display("FAIL midrun_clear8 got=%b want=%b", sum8, 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (sum4 !== 5'd0) begin
            n_err++;
            $display("FAIL midrun_stay_clear got=%b want=%b", sum4, 5'd0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sum4 !== 5'd19) begin
            n_err++;
            $display("FAIL midrun_recover4 got=%b want=%b", sum4, 5'd19);
        end
        n_cmp++;
        if (sum8 !== 9'd300) begin
            n_err++;
            $display("FAIL midrun_recover8 got=%b want=%b", sum8, 9'd300);
        end
    endtask

    task automatic test_exhaustive();
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(4'(x), 4'(y), 1'(c));
                    @(posedge clk); #1;
                    n_cmp++;
                    if (sum4 !== 5'(x + y + c)) begin
                        n_err++;
                        $display("FAIL exhaustive a=%0d b=%0d cin=%0d got=%0d want=%0d",
                                 x, y, c, sum4, x + y + c);
                    end
                end
            end
        end
    endtask

    task automatic test_wide_random();
        logic [7:0] q_a [$];
        logic [7:0] q_b [$];
        logic       q_c [$];
        q_a = '{8'hFF, 8'hFF, 8'h0F, 8'h00};
        q_b = '{8'hFF, 8'h00, 8'h01, 8'h00};
        q_c = '{1'b1,  1'b1,  1'b0,  1'b0};
        for (int i = 0; i < 300; i++) begin
            q_a.push_back(8'($urandom));
            q_b.push_back(8'($urandom));
            q_c.push_back(1'($urandom));
        end
        for (int i = 0; i < q_a.size(); i++) begin
            @(negedge clk);
            a8 = q_a[i]; b8 = q_b[i]; cin8 = q_c[i];
            @(posedge clk); #1;
            n_cmp++;
            if (sum8 !== ref8(q_a[i], q_b[i], q_c[i])) begin
                n_err++;
                $display("FAIL wide[%0d] a=%h b=%h cin=%b got=%h want=%h",
                         i, q_a[i], q_b[i], q_c[i], sum8, ref8(q_a[i], q_b[i], q_c[i]));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_single_change();
        test_midrun_reset();
        test_exhaustive();
        test_wide_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/carry_select_adder.md
# carry_select_adder

Registered carry-select adder: adds two unsigned operands plus a carry-in and presents the full-width sum, including carry-out as MSB, one clock after the operands are sampled. It is the carry-select entry in the adder/multiplier comparison set and sits beside the ripple-carry and carry-lookahead variants with the same operand interface. The internal carry-select structure is what is being characterised; the output register gives a clean timing boundary.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits, ≥ 2.
- `BLOCK_W`, default 2: bits per carry-select block, must divide `WIDTH`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `a`, input, `WIDTH`: operand A, unsigned.
- `b`, input, `WIDTH`: operand B, unsigned.
- `cin`, input, 1: carry-in.
- `sum`, output, `WIDTH+1`: registered result. `sum[WIDTH]` is the carry-out, `sum[WIDTH-1:0]` the sum bits.

## Operation
- Required result: `sum = a + b + cin`, computed at width `WIDTH+1`. There is no overflow or wrap; the maximum is `2*(2^WIDTH-1)+1`, which is 31 for `WIDTH=4`.
- The operands split into `WIDTH/BLOCK_W` blocks, LSB first.
- **Block 0:** a single ripple block driven by `cin`.
- **Blocks 1..N-1:** each holds two ripple blocks precomputed in parallel, one assuming carry-in 0 and one assuming carry-in 1.
  - The real carry out of the previous block selects both the sum bits and the carry-out of this block through a 2:1 mux.
  - The carry-out of the last block becomes `sum[WIDTH]`.
- Operand-to-register path is combinational and has no handshake: every cycle samples `a`, `b`, `cin`.
- Reset:
  - While `rst_n` is low, `sum` is all zeros, asynchronously.
  - On deassertion, the first rising edge loads the sum of the current inputs.
- X/unknown inputs propagate to `sum`. No masking is required.

## Timing
- Latency: 1 cycle. Inputs applied before rising edge k appear on `sum` after edge k and hold until edge k+1.
- Throughput: one addition per cycle. Changing any single input changes `sum` at the next edge.
- Reset asserted mid-operation clears `sum` immediately, without waiting for a clock. An in-flight result is discarded.
- Critical path: block-0 ripple, then (N-1) mux stages, then the register. It must not contain a full `WIDTH`-bit ripple.

## Structure
- Sub-module `ripple_block`:
  - Parameter `W`.
  - Ports `a[W-1:0]`, `b[W-1:0]`, `ci`, `s[W-1:0]`, `co`.
  - Built from full-adder equations.
- Top level:
  - Instantiates one `ripple_block` for block 0 and two per higher block in a generate loop.
  - Contains the select muxes and the output register.
- No shared package is needed. Width checks (`WIDTH % BLOCK_W == 0`) are an elaboration-time assertion in the top level.

## Test plan
Defaults `WIDTH=4`, `BLOCK_W=2`. Each case releases reset, applies the inputs and checks `sum` one edge later.
- Reset: `rst_n=0` with `a=4'b1111`, `b=4'b1111`, `cin=1` → `sum=5'b00000`. Hold reset across several edges; `sum` stays zero.
- Basic, no carry-out:
  - `a=0101`, `b=0011`, `cin=0` → `sum=01000`.
  - `a=0000`, `b=0000`, `cin=1` → `sum=00001`.
- Carry across block boundary to carry-out:
  - `a=1111`, `b=0001`, `cin=1` → `sum=10001`.
  - `a=1010`, `b=0110`, `cin=0` → `sum=10000`.
- Upper block selects its carry-1 path:
  - `a=1010`, `b=1010`, `cin=0` → `sum=10100`.
  - `a=1100`, `b=0011`, `cin=1` → `sum=10000`.
- Mid-run reset and single-input changes:
  - Change `a`, then `b`, then `cin` on successive cycles; each intermediate `sum` matches `a+b+cin` one edge later.
  - Pulse `rst_n` low between edges → `sum` clears immediately and recovers on the next edge after release.
- Exhaustive sweep: all 512 combinations of `a`, `b`, `cin` compared against a reference `a+b+cin` with a 1-cycle delay. Repeat for `WIDTH=8`, `BLOCK_W=4` with random vectors.
